// File: rtl/pulse_seq_cpmg.sv
// CPMG pulse-train generator: one excitation pulse plus cp+1 refocusing pulses per period, with
// SYNC marker, receiver inhibit, round-robin phase channels and double-buffered timing words.
module pulse_seq_cpmg #(
  parameter int unsigned CW       = 32,
  parameter int unsigned PW       = 16,
  parameter int unsigned NW       = 8,
  parameter int unsigned NCH      = 4,
  parameter int unsigned SYNC_W   = 8,
  parameter int unsigned INH_TAIL = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [CW-1:0]  per,
  input  logic [PW-1:0]  p1wid,
  input  logic [PW-1:0]  del,
  input  logic [PW-1:0]  p2wid,
  input  logic [NW-1:0]  cp,
  input  logic           bl,
  input  logic           oneshot,
  input  logic           rxd,
  output logic           sync_on,
  output logic           pulse_on,
  output logic           inhib,
  output logic [NCH-1:0] phase,
  output logic           running
);

  localparam int unsigned CntW = PW + 1;
  localparam int unsigned PhW  = $clog2(NCH);

  typedef struct packed {
    logic [CW-1:0] per;
    logic [PW-1:0] p1wid;
    logic [PW-1:0] del;
    logic [PW-1:0] p2wid;
    logic [NW-1:0] cp;
    logic          oneshot;
  } cfg_t;

  typedef enum logic [2:0] {
    StIdle,
    StP1,
    StGap1,
    StP2,
    StGap2,
    StTail,
    StWait
  } state_e;

  // Refocusing channels rotate through bits 1..NCH-1; bit 0 belongs to the excitation pulse.
  function automatic logic [PhW-1:0] ph_next(input logic [PhW-1:0] p);
    return (p == PhW'(NCH - 1)) ? PhW'(1) : p + PhW'(1);
  endfunction

  cfg_t            cfg_in, load_cfg;
  cfg_t            pend_q, pend_d;
  cfg_t            act_q, act_d;
  logic            pend_valid_q, pend_valid_d;
  state_e          state_q, state_d;
  logic [CW-1:0]   t_q, t_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NW-1:0]   rem_q, rem_d;
  logic [PhW-1:0]  ph_q, ph_d;

  logic            wrap, start, load, enter;
  logic            run_d, sync_d, pulse_d, inhib_d;
  logic [NCH-1:0]  phase_d;
  logic            run_q, sync_q, pulse_q, inhib_q;
  logic [NCH-1:0]  phase_q;

  always_comb begin
    cfg_in.per     = per;
    cfg_in.p1wid   = p1wid;
    cfg_in.del     = del;
    cfg_in.p2wid   = p2wid;
    cfg_in.cp      = cp;
    cfg_in.oneshot = oneshot;

    // Bank handling: idle starts use only the registered pending bank, while a period boundary
    // also accepts a strobe arriving on its final cycle.
    wrap         = (state_q != StIdle) && (t_q == act_q.per - CW'(1));
    start        = 1'b0;
    load         = 1'b0;
    load_cfg     = pend_q;
    pend_d       = rxd ? cfg_in : pend_q;
    pend_valid_d = pend_valid_q | rxd;
    act_d        = act_q;

    if (state_q == StIdle) begin
      if (pend_valid_q) begin
        load         = 1'b1;
        load_cfg     = pend_q;
        pend_valid_d = rxd;
      end
    end else if (wrap) begin
      if (pend_valid_q || rxd) begin
        load         = 1'b1;
        load_cfg     = rxd ? cfg_in : pend_q;
        pend_valid_d = 1'b0;
      end else begin
        start = !act_q.oneshot;
      end
    end

    if (load) begin
      act_d = load_cfg;
      start = (load_cfg.per > CW'(1));
    end

    state_d = state_q;
    t_d     = t_q + CW'(1);
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    ph_d    = ph_q;
    enter   = 1'b0;

    if (start) begin
      state_d = StP1;
      t_d     = '0;
      rem_d   = act_d.cp;
      ph_d    = PhW'(1);
      enter   = 1'b1;
    end else if (state_q == StIdle || wrap) begin
      state_d = StIdle;
      t_d     = '0;
    end else if (state_q != StWait) begin
      if (cnt_q > CntW'(1)) begin
        cnt_d = cnt_q - CntW'(1);
      end else begin
        enter = 1'b1;
        case (state_q)
          StP1:   state_d = StGap1;
          StGap1: state_d = StP2;
          StP2: begin
            if (rem_q != '0) begin
              state_d = StGap2;
              rem_d   = rem_q - NW'(1);
              ph_d    = ph_next(ph_q);
            end else begin
              state_d = StTail;
            end
          end
          StGap2: state_d = StP2;
          default: state_d = StWait;
        endcase
      end
    end

    // Zero-length segments fall through to their successor within the same cycle. With both
    // p2wid and del zero the remaining refocusing train has no duration at all.
    if (enter && state_d == StP1 && act_d.p1wid == '0) state_d = StGap1;
    if (enter && state_d == StGap1 && act_d.del == '0) state_d = StP2;
    if (enter && state_d == StGap2 && act_d.del == '0) state_d = StP2;
    if (enter && state_d == StP2 && act_d.p2wid == '0) begin
      if (rem_d != '0 && act_d.del != '0) begin
        state_d = StGap2;
        rem_d   = rem_d - NW'(1);
        ph_d    = ph_next(ph_d);
      end else begin
        state_d = StTail;
      end
    end
    if (enter && state_d == StTail && INH_TAIL == 0) state_d = StWait;

    if (enter) begin
      case (state_d)
        StP1:    cnt_d = CntW'(act_d.p1wid);
        StGap1:  cnt_d = CntW'(act_d.del);
        StP2:    cnt_d = CntW'(act_d.p2wid);
        StGap2:  cnt_d = {act_d.del, 1'b0};
        StTail:  cnt_d = CntW'(INH_TAIL);
        default: cnt_d = '0;
      endcase
    end

    run_d   = (state_d != StIdle);
    sync_d  = run_d && (t_d < CW'(SYNC_W));
    pulse_d = (state_d == StP1 || state_d == StP2) && !bl;
    inhib_d = run_d && (state_d != StWait);
    phase_d = '0;
    if (pulse_d) begin
      phase_d = (state_d == StP1) ? NCH'(1) : (NCH'(1) << ph_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      act_q        <= '0;
      state_q      <= StIdle;
      t_q          <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      ph_q         <= '0;
      run_q        <= 1'b0;
      sync_q       <= 1'b0;
      pulse_q      <= 1'b0;
      inhib_q      <= 1'b0;
      phase_q      <= '0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      act_q        <= act_d;
      state_q      <= state_d;
      t_q          <= t_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      ph_q         <= ph_d;
      run_q        <= run_d;
      sync_q       <= sync_d;
      pulse_q      <= pulse_d;
      inhib_q      <= inhib_d;
      phase_q      <= phase_d;
    end
  end

  assign running  = run_q;
  assign sync_on  = sync_q;
  assign pulse_on = pulse_q;
  assign inhib    = inhib_q;
  assign phase    = phase_q;

endmodule

// File: tb/tb_pulse_seq_cpmg.sv
// Directed bench for pulse_seq_cpmg: traces whole periods and compares against hand-computed
// {running, sync_on, pulse_on, inhib, phase} vectors; a second instance covers NCH=3.
module tb_pulse_seq_cpmg;

  logic        clk = 1'b0;
  logic        reset, bl, oneshot, rxd;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid;
  logic [7:0]  cp;
  logic        sync_on, pulse_on, inhib, running;
  logic [3:0]  phase;
  logic        sync_on3, pulse_on3, inhib3, running3;
  logic [2:0]  phase3;

  always #5 clk = ~clk;

  pulse_seq_cpmg #(.NCH(4)) dut (
    .clk(clk), .reset(reset), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .cp(cp),
    .bl(bl), .oneshot(oneshot), .rxd(rxd), .sync_on(sync_on), .pulse_on(pulse_on),
    .inhib(inhib), .phase(phase), .running(running)
  );

  pulse_seq_cpmg #(.NCH(3)) dut3 (
    .clk(clk), .reset(reset), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .cp(cp),
    .bl(bl), .oneshot(oneshot), .rxd(rxd), .sync_on(sync_on3), .pulse_on(pulse_on3),
    .inhib(inhib3), .phase(phase3), .running(running3)
  );

  // Expected word layout: {running, sync_on, pulse_on, inhib, phase[3:0]}.
  typedef struct {
    int         scen;
    int         t;
    logic [7:0] exp;
  } vec_t;

  vec_t       tab[$];
  logic [7:0] tr  [0:299];
  logic [6:0] tr3 [0:299];
  int         checks = 0;
  int         errors = 0;
  int         t3_tab [8] = '{0, 5, 15, 25, 35, 45, 55, 9};
  logic [6:0] e3_tab [8] = '{7'b1111_001, 7'b1111_010, 7'b1011_100, 7'b1011_010,
                             7'b1011_100, 7'b1011_010, 7'b1011_100, 7'b1001_000};

  task automatic add(input int scen, input int t, input logic [7:0] exp);
    vec_t v;
    v.scen = scen;
    v.t    = t;
    v.exp  = exp;
    tab.push_back(v);
  endtask

  task automatic set_cfg(input int p, input int w1, input int d, input int w2, input int c,
                         input bit os);
    per     = 32'(p);
    p1wid   = 16'(w1);
    del     = 16'(d);
    p2wid   = 16'(w2);
    cp      = 8'(c);
    oneshot = os;
  endtask

  // After this returns, the next negedge sample is t=0 of the first period.
  task automatic load(input int p, input int w1, input int d, input int w2, input int c,
                      input bit os);
    @(negedge clk);
    set_cfg(p, w1, d, w2, c, os);
    rxd = 1'b1;
    @(negedge clk);
    rxd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_trace(input int n, input int rxd_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr[i]  = {running, sync_on, pulse_on, inhib, phase};
      tr3[i] = {running3, sync_on3, pulse_on3, inhib3, phase3};
      rxd    = (i == rxd_at);
    end
    rxd = 1'b0;
  endtask

  task automatic check_scen(input int scen, input string name);
    foreach (tab[k]) begin
      if (tab[k].scen == scen) begin
        checks++;
        if (tr[tab[k].t] !== tab[k].exp) begin
          errors++;
          $display("FAIL %s t=%0d got %b expected %b", name, tab[k].t, tr[tab[k].t],
                   tab[k].exp);
        end
      end
    end
  endtask

  task automatic check1(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  initial begin
    // 1: basic per=100 with reload to per=50 requested at t=30 of the second period.
    add(1, 0, 8'hF1);   add(1, 3, 8'hF1);   add(1, 4, 8'hD0);   add(1, 7, 8'hD0);
    add(1, 8, 8'h90);   add(1, 13, 8'h90);  add(1, 14, 8'hB2);  add(1, 21, 8'hB2);
    add(1, 22, 8'h90);  add(1, 41, 8'h90);  add(1, 42, 8'hB4);  add(1, 49, 8'hB4);
    add(1, 50, 8'h90);  add(1, 65, 8'h90);  add(1, 66, 8'h80);  add(1, 99, 8'h80);
    add(1, 100, 8'hF1); add(1, 142, 8'hB4); add(1, 166, 8'h80); add(1, 199, 8'h80);
    add(1, 200, 8'hF1); add(1, 230, 8'h90); add(1, 249, 8'hB4); add(1, 250, 8'hF1);
    // 2: truncation per=20, cp=0, then rxd coincident with t=per-1 switching to per=30.
    add(2, 0, 8'hF1);   add(2, 3, 8'hF1);   add(2, 4, 8'hD0);   add(2, 7, 8'hD0);
    add(2, 8, 8'h90);   add(2, 13, 8'h90);  add(2, 14, 8'hB2);  add(2, 19, 8'hB2);
    add(2, 20, 8'hF1);  add(2, 34, 8'hB2);  add(2, 39, 8'hB2);  add(2, 40, 8'hF1);
    add(2, 60, 8'hB2);  add(2, 61, 8'hB2);  add(2, 62, 8'h90);  add(2, 69, 8'h90);
    add(2, 70, 8'hF1);
    // 3: block suppresses pulse/phase only.
    add(3, 0, 8'hD0);   add(3, 3, 8'hD0);   add(3, 14, 8'h90);  add(3, 42, 8'h90);
    add(3, 65, 8'h90);  add(3, 66, 8'h80);
    // 4: one-shot per=30; 5: restart after a fresh rxd.
    add(4, 0, 8'hF1);   add(4, 14, 8'hB2);  add(4, 21, 8'hB2);  add(4, 22, 8'h90);
    add(4, 29, 8'h90);  add(4, 30, 8'h00);  add(4, 39, 8'h00);
    add(5, 0, 8'hF1);   add(5, 1, 8'hF1);
    // 6: per=0 never starts.
    add(6, 0, 8'h00);   add(6, 9, 8'h00);
    // 7: p2wid=0, cp=3: refocusing starts at 14,34,54,74, tail 74..89.
    add(7, 0, 8'hF1);   add(7, 3, 8'hF1);   add(7, 4, 8'hD0);   add(7, 13, 8'h90);
    add(7, 14, 8'h90);  add(7, 34, 8'h90);  add(7, 74, 8'h90);  add(7, 89, 8'h90);
    add(7, 90, 8'h80);  add(7, 94, 8'h80);
    // 8: phase rotation, p1=2 del=3 p2=4 cp=5: pulses at 5,15,...,55.
    add(8, 0, 8'hF1);   add(8, 2, 8'hD0);   add(8, 5, 8'hF2);   add(8, 15, 8'hB4);
    add(8, 25, 8'hB8);  add(8, 35, 8'hB2);  add(8, 45, 8'hB4);  add(8, 55, 8'hB8);
    add(8, 58, 8'hB8);  add(8, 59, 8'h90);  add(8, 74, 8'h90);  add(8, 75, 8'h80);

    reset = 1'b1;
    rxd   = 1'b0;
    bl    = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check1("reset_state", {running, sync_on, pulse_on, inhib, phase}, 8'h00);
    @(negedge clk);
    check1("idle_after_reset", {running, sync_on, pulse_on, inhib, phase}, 8'h00);

    load(100, 4, 10, 8, 1, 1'b0);
    set_cfg(50, 4, 10, 8, 1, 1'b0);
    run_trace(260, 130);
    check_scen(1, "basic_reload");

    do_reset();
    load(20, 4, 10, 8, 0, 1'b0);
    set_cfg(30, 4, 10, 8, 0, 1'b0);
    run_trace(75, 39);
    check_scen(2, "truncate_coincident");

    do_reset();
    bl = 1'b1;
    load(100, 4, 10, 8, 1, 1'b0);
    run_trace(70, -1);
    check_scen(3, "block");
    bl = 1'b0;

    do_reset();
    load(30, 4, 10, 8, 1, 1'b1);
    run_trace(40, -1);
    check_scen(4, "oneshot");
    load(30, 4, 10, 8, 1, 1'b1);
    run_trace(2, -1);
    check_scen(5, "oneshot_restart");

    do_reset();
    load(0, 4, 10, 8, 1, 1'b0);
    run_trace(10, -1);
    check_scen(6, "per_zero");

    do_reset();
    load(100, 4, 10, 0, 3, 1'b0);
    run_trace(95, -1);
    check_scen(7, "p2wid_zero");

    do_reset();
    load(200, 2, 3, 4, 5, 1'b0);
    run_trace(80, -1);
    check_scen(8, "phase_nch4");
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (tr3[t3_tab[k]] !== e3_tab[k]) begin
        errors++;
        $display("FAIL phase_nch3 t=%0d got %b expected %b", t3_tab[k], tr3[t3_tab[k]],
                 e3_tab[k]);
      end
    end

    // Reset in the middle of the first refocusing pulse.
    do_reset();
    load(100, 4, 10, 8, 1, 1'b0);
    run_trace(17, -1);
    check1("mid_p2_before_reset", tr[16], 8'hB2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check1("reset_mid_p2", {running, sync_on, pulse_on, inhib, phase}, 8'h00);
    repeat (10) @(negedge clk);
    check1("no_resume_after_reset", {running, sync_on, pulse_on, inhib, phase}, 8'h00);

    // rxd coincident with reset is dropped.
    set_cfg(100, 4, 10, 8, 1, 1'b0);
    reset = 1'b1;
    rxd   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rxd   = 1'b0;
    repeat (5) @(negedge clk);
    check1("rxd_with_reset", {running, sync_on, pulse_on, inhib, phase}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_seq_cpmg.md
# pulse_seq_cpmg

Parametrised CPMG pulse-train generator: the next-generation `pulses` engine behind `pulse_control`. Produces a repeating sequence of one excitation pulse plus a programmable number of refocusing pulses, with a SYNC marker, a receiver-inhibit window and round-robin phase-channel selection for phase cycling. New timing words arrive from the UART control block and are double-buffered so they only take effect on a period boundary. Continuous and one-shot modes are supported.

## Interface
Parameters:
- `CW`, 32, period counter / `per` width
- `PW`, 16, width of `p1wid`, `del`, `p2wid`
- `NW`, 8, width of `cp` (refocusing pulse count)
- `NCH`, 4, number of phase channels (≥2)
- `SYNC_W`, 8, SYNC pulse length in cycles
- `INH_TAIL`, 16, cycles inhibit stays high after last refocusing pulse ends

Ports:
- `clk` in 1: single clock (PLL domain)
- `reset` in 1: synchronous, active-high
- `per` in CW: period length in cycles
- `p1wid` in PW: excitation pulse width
- `del` in PW: inter-pulse delay τ
- `p2wid` in PW: refocusing pulse width
- `cp` in NW: refocusing pulses per period = `cp`+1
- `bl` in 1: block, suppresses `pulse_on` and `phase` only
- `oneshot` in 1: 1 = run exactly one period per load
- `rxd` in 1: one-cycle strobe, new config valid on all config inputs
- `sync_on` out 1: SYNC marker
- `pulse_on` out 1: switch drive
- `inhib` out 1: receiver inhibit
- `phase` out NCH: one-hot phase channel of current pulse, 0 when no pulse
- `running` out 1: a period is in progress

## Operation
- Config: on `rxd`, all config inputs captured into a pending bank and `pend` set. The active bank loads from pending at the next period start (t=0), or on the cycle after capture if not running. `rxd` while `pend` already set overwrites pending (last wins).
- Period: counter t runs 0..`per`-1 from the active bank, wraps to 0. `per`=0 or `per`=1: no period starts, `running`=0.
- FSM states: IDLE, P1, GAP1, P2, GAP2, TAIL, WAIT. t=0 → P1 (skipped to GAP1 if `p1wid`=0) for `p1wid` cycles → GAP1 for `del` cycles → P2 for `p2wid` cycles → if pulses remaining, GAP2 for 2·`del` cycles → P2; else TAIL for `INH_TAIL` cycles → WAIT until wrap. Refocusing pulse k starts at t = `p1wid`+`del`+k·(`p2wid`+2·`del`), k=0..`cp`.
- Width rule: schedule computed with down-counters of width PW+1 (2·`del` never overflows); no absolute sum is formed.
- Truncation: when t reaches `per`-1, the FSM returns to P1 at the wrap regardless of state; unfinished pulses are cut.
- `sync_on` = 1 for t < min(`SYNC_W`, `per`).
- `pulse_on` = 1 in P1 and P2 unless `bl`. `p2wid`=0: P2 lasts 0 cycles, no output, schedule continues.
- `phase`: P1 → bit 0. Refocusing pulse k → bit 1+(k mod (NCH-1)). Restarts at bit 1 every period. Forced 0 when `bl` or no pulse.
- `inhib` = 1 from t=0 through the end of TAIL, independent of `bl`.
- One-shot: with `oneshot`=1 in the active bank, after the single period the FSM returns to IDLE, `running`=0, and it waits for the next `rxd`. Continuous mode loops indefinitely.
- Reset: FSM IDLE, both banks and `pend` cleared, t=0, all outputs 0. Reset mid-period aborts immediately; nothing resumes until a fresh `rxd`.

## Timing
- All outputs registered. For period-relative cycle t, outputs reflect t in the same cycle t.
- Idle start: `rxd` high at cycle c → active load at c+1 → t=0 (first `sync_on`/`pulse_on` high) at c+2.
- Running: `rxd` at any cycle → new values apply from the next t=0. The period in flight completes unchanged.
- `rxd` coincident with t=`per`-1: the new bank applies at the immediately following t=0.
- `bl` is sampled every cycle and takes effect on outputs the next cycle.
- `reset` takes priority over `rxd` in the same cycle.

## Test plan
- Basic: per=100, p1wid=4, del=10, p2wid=8, cp=1, NCH=4, rxd at c → pulse_on high t=0–3, 14–21, 42–49. phase = 0001, 0010, 0100. inhib high t=0–65. sync_on high t=0–7. Repeats with period 100.
- Reload mid-period: running per=100, rxd with per=50 at t=30 → current period ends at t=99, next period has length 50.
- Truncation: per=20, p1wid=4, del=10, p2wid=8, cp=0 → pulse_on high t=0–3 and t=14–19 only, inhib high t=0–19, clean restart each period.
- Block and oneshot: bl=1 → pulse_on/phase 0 while sync_on and inhib unchanged. oneshot=1, per=30 → exactly one period, then running=0 and outputs 0 until next rxd.
- Edges: per=0 → running stays 0. p2wid=0, cp=3 → only P1 pulses, inhib still spans the full schedule + INH_TAIL. Phase wrap with cp=5, NCH=3 → refocus phases 010, 100, 010, 100, 010, 100.
- Reset mid-P2 → all outputs 0 the next cycle, no output until rxd. rxd and reset in the same cycle → rxd ignored.
